// File: rtl/key_sched_iter_pkg.sv
// key_sched_iter_pkg: DES key-schedule constants, FSM encoding and rotation helpers
// shared by the iterative key scheduler and its permutation boxes.
package key_sched_iter_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int RK_W   = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // DES bit numbering: entry n selects input bit n, where bit 1 is the MSB.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Shift table S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
    function automatic logic [1:0] shift_amt(input logic [3:0] r);
        return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                                input logic [1:0] n,
                                                input logic left);
        logic [HALF_W-1:0] l1, l2, r1, r2;
        l1 = {x[26:0], x[27]};
        l2 = {x[25:0], x[27:26]};
        r1 = {x[0], x[27:1]};
        r2 = {x[1:0], x[27:2]};
        return left ? ((n == 2'd2) ? l2 : l1) : ((n == 2'd2) ? r2 : r1);
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// p_box_56_48: DES permuted choice 2, compresses C||D to a round key; pure wiring.
module p_box_56_48
    import key_sched_iter_pkg::*;
(
    input  logic [CD_W-1:0] i_data,
    output logic [RK_W-1:0] o_data
);
    for (genvar i = 0; i < RK_W; i++) begin : g_pc2
        assign o_data[RK_W-1-i] = i_data[CD_W-PC2_TAB[i]];
    end
endmodule

// File: rtl/p_box_64_56.sv
// p_box_64_56: DES permuted choice 1, drops parity bits; pure wiring.
module p_box_64_56
    import key_sched_iter_pkg::*;
(
    input  logic [KEY_W-1:0] i_data,
    output logic [CD_W-1:0]  o_data
);
    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign o_data[CD_W-1-i] = i_data[KEY_W-PC1_TAB[i]];
    end
endmodule

// File: rtl/key_sched_iter.sv
// key_sched_iter: iterative DES key scheduler, one 48-bit round key per handshake.
// Decrypt walks the schedule backwards by rotating right from C0D0 (== C16D16).
module key_sched_iter
    import key_sched_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] i_init_key,
    input  logic             i_encrypt_decrypt,
    input  logic             i_key_load,
    output logic             o_key_ready,
    input  logic             i_abort,
    output logic [RK_W-1:0]  o_round_key,
    output logic             o_round_key_valid,
    input  logic             i_round_key_ready,
    output logic [3:0]       o_round_num,
    output logic             o_last_key
);
    state_t            r_state, w_state_nx;
    logic [CD_W-1:0]   r_cd;
    logic [3:0]        r_ctr;
    logic              r_enc;
    logic [CD_W-1:0]   w_pc1;
    logic [CD_W-1:0]   w_cd_rot;
    logic [CD_W-1:0]   w_pc2_in;
    logic [RK_W-1:0]   w_key;
    logic [1:0]        w_amt;
    logic              w_run;
    logic              w_accept;
    logic              w_load;

    p_box_64_56 u_pc1 (.i_data(i_init_key), .o_data(w_pc1));
    p_box_56_48 u_pc2 (.i_data(w_pc2_in),   .o_data(w_key));

    assign w_run    = (r_state == RUN);
    assign w_load   = !w_run && i_key_load;
    assign w_accept = w_run && !i_abort && i_round_key_ready;
    // Decrypt undoes encrypt round 15-ctr, so it uses the mirrored shift entry.
    assign w_amt    = r_enc ? shift_amt(r_ctr) : shift_amt(4'd15 - r_ctr);
    assign w_cd_rot = {rot28(r_cd[CD_W-1:HALF_W], w_amt, r_enc),
                       rot28(r_cd[HALF_W-1:0],    w_amt, r_enc)};
    assign w_pc2_in = r_enc ? w_cd_rot : r_cd;

    always_comb begin
        w_state_nx = r_state;
        if (w_load)
            w_state_nx = RUN;
        else if (w_run && i_abort)
            w_state_nx = IDLE;
        else if (w_accept && r_ctr == 4'd15)
            w_state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cd  <= '0;
            r_ctr <= '0;
            r_enc <= 1'b0;
        end else if (w_load) begin
            r_cd  <= w_pc1;
            r_ctr <= '0;
            r_enc <= i_encrypt_decrypt;
        end else if (w_run && i_abort) begin
            r_ctr <= '0;
        end else if (w_accept) begin
            r_cd  <= w_cd_rot;
            r_ctr <= r_ctr + 4'd1;
        end
    end

    assign o_key_ready       = !w_run;
    assign o_round_key_valid = w_run;
    assign o_round_key       = w_run ? w_key : '0;
    assign o_round_num       = w_run ? r_ctr : 4'd0;
    assign o_last_key        = w_run && (r_ctr == 4'd15);
endmodule
